// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Shared definitions for the decode stage and the execute stage behind it:
// instruction opcodes, the 4-bit execute command encoding, the ID/EX payload
// structure and a sign-extension helper.
// -----------------------------------------------------------------------------
package id_stage_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    // Execute-stage command encoding
    typedef enum logic [3:0] {
        EXE_NOP = 4'd0,
        EXE_ADD = 4'd1,
        EXE_SUB = 4'd2,
        EXE_AND = 4'd3,
        EXE_OR  = 4'd4,
        EXE_NOR = 4'd5,
        EXE_XOR = 4'd6,
        EXE_SLA = 4'd7,
        EXE_SLL = 4'd8,
        EXE_SRA = 4'd9,
        EXE_SRL = 4'd10
    } exe_cmd_e;

    // Everything handed from decode to execute in one pipeline slot
    typedef struct packed {
        logic [31:0] pc;
        exe_cmd_e    exe_cmd;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] st_val;
        logic [4:0]  dest;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
    } id_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x 32-bit general-purpose registers, two asynchronous read ports and one
// synchronous write port. R0 is hard-wired to zero. A read of the register
// being written in the same cycle returns the incoming write data.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_rd_addr1/2             read addresses
//   o_rd_data1/2             read data (combinational)
//   i_wr_en/addr/data        write port, committed on the rising edge
// -----------------------------------------------------------------------------
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_rd_addr1,
    input  logic [4:0]  i_rd_addr2,
    output logic [31:0] o_rd_data1,
    output logic [31:0] o_rd_data2,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);

    logic [31:0] r_regs [32];

    // NOTE: this array is cleared by reset, so it builds from flops rather than
    // a RAM macro; the reset-to-zero register contents are architectural here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != 5'd0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Write-through bypass keeps decode from reading a stale value while
    // writeback commits the same register at the end of this cycle.
    assign o_rd_data1 = (i_rd_addr1 == 5'd0)                      ? 32'd0     :
                        (i_wr_en && (i_wr_addr == i_rd_addr1))    ? i_wr_data :
                                                                    r_regs[i_rd_addr1];
    assign o_rd_data2 = (i_rd_addr2 == 5'd0)                      ? 32'd0     :
                        (i_wr_en && (i_wr_addr == i_rd_addr2))    ? i_wr_data :
                                                                    r_regs[i_rd_addr2];

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Instruction-decode stage: IF/ID pipeline register, register file, decoder,
// branch resolution and the ID/EX pipeline register.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   if_instruction, if_pc          fetched word and its byte address
//   stall                          hold IF/ID, send a bubble into ID/EX
//   wb_en, wb_dest, wb_value       register-file write port from writeback
//   branch_taken, branch_address   combinational redirect to fetch
//   ex_*                           registered ID/EX payload for execute
// -----------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [31:0] ex_pc,
    output logic [3:0]  ex_exe_cmd,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [31:0] ex_st_val,
    output logic [4:0]  ex_dest,
    output logic        ex_wb_en,
    output logic        ex_mem_r_en,
    output logic        ex_mem_w_en
);

    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    id_ex_t      r_idex;

    logic [5:0]  w_op;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd_r;
    logic [31:0] w_imm;
    logic [31:0] w_rd_data1;
    logic [31:0] w_rd_data2;
    logic        w_branch_cond;
    id_ex_t      w_dec;

    // ---------------------------------------------------------------- IF/ID
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
        end else if (!stall) begin
            if (branch_taken) begin
                // Squash the wrong-path fetch into a NOP slot
                r_ifid_instr <= '0;
                r_ifid_pc    <= '0;
            end else begin
                r_ifid_instr <= if_instruction;
                r_ifid_pc    <= if_pc;
            end
        end
    end

    // ---------------------------------------------------------------- fields
    assign w_op   = r_ifid_instr[31:26];
    assign w_rs1  = r_ifid_instr[25:21];
    assign w_rs2  = r_ifid_instr[20:16];
    assign w_rd_r = r_ifid_instr[15:11];
    assign w_imm  = sext16(r_ifid_instr[15:0]);

    register_file u_register_file (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr1 (w_rs1),
        .i_rd_addr2 (w_rs2),
        .o_rd_data1 (w_rd_data1),
        .o_rd_data2 (w_rd_data2),
        .i_wr_en    (wb_en),
        .i_wr_addr  (wb_dest),
        .i_wr_data  (wb_value)
    );

    // ---------------------------------------------------------------- decode
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = r_ifid_pc;
        w_branch_cond = 1'b0;

        unique case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
                case (w_op)
                    OP_ADD:  w_dec.exe_cmd = EXE_ADD;
                    OP_SUB:  w_dec.exe_cmd = EXE_SUB;
                    OP_AND:  w_dec.exe_cmd = EXE_AND;
                    OP_OR:   w_dec.exe_cmd = EXE_OR;
                    OP_NOR:  w_dec.exe_cmd = EXE_NOR;
                    OP_XOR:  w_dec.exe_cmd = EXE_XOR;
                    OP_SLA:  w_dec.exe_cmd = EXE_SLA;
                    OP_SLL:  w_dec.exe_cmd = EXE_SLL;
                    OP_SRA:  w_dec.exe_cmd = EXE_SRA;
                    default: w_dec.exe_cmd = EXE_SRL;
                endcase
                w_dec.val1  = w_rd_data1;
                w_dec.val2  = w_rd_data2;
                w_dec.dest  = w_rd_r;
                w_dec.wb_en = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_LD: begin
                if (w_op == OP_SUBI) begin
                    w_dec.exe_cmd = EXE_SUB;
                end else begin
                    w_dec.exe_cmd = EXE_ADD;
                end
                w_dec.val1     = w_rd_data1;
                w_dec.val2     = w_imm;
                w_dec.dest     = w_rs2;
                w_dec.wb_en    = 1'b1;
                w_dec.mem_r_en = (w_op == OP_LD);
            end
            OP_ST: begin
                // Address = base + offset; store data rides along in st_val
                w_dec.exe_cmd  = EXE_ADD;
                w_dec.val1     = w_rd_data1;
                w_dec.val2     = w_imm;
                w_dec.st_val   = w_rd_data2;
                w_dec.mem_w_en = 1'b1;
            end
            OP_BEZ:  w_branch_cond = (w_rd_data1 == 32'd0);
            OP_BNE:  w_branch_cond = (w_rd_data1 != w_rd_data2);
            OP_JMP:  w_branch_cond = 1'b1;
            default: ; // NOP and unassigned opcodes leave the defaults
        endcase
    end

    assign branch_taken   = w_branch_cond && !stall;
    assign branch_address = r_ifid_pc + 32'd4 + (w_imm << 2);

    // ---------------------------------------------------------------- ID/EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex <= '0;
        end else if (stall) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_dec;
        end
    end

    assign ex_pc       = r_idex.pc;
    assign ex_exe_cmd  = r_idex.exe_cmd;
    assign ex_val1     = r_idex.val1;
    assign ex_val2     = r_idex.val2;
    assign ex_st_val   = r_idex.st_val;
    assign ex_dest     = r_idex.dest;
    assign ex_wb_en    = r_idex.wb_en;
    assign ex_mem_r_en = r_idex.mem_r_en;
    assign ex_mem_w_en = r_idex.mem_w_en;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Self-checking bench for id_stage: directed scenarios followed by a random
// instruction stream compared against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_id_stage;

    // Opcodes as the instruction set defines them
    localparam logic [5:0] T_NOP = 6'b000000, T_ADD = 6'b000001, T_SUB = 6'b000011;
    localparam logic [5:0] T_ADDI = 6'b100000, T_SUBI = 6'b100001, T_LD = 6'b100100;
    localparam logic [5:0] T_ST = 6'b100101, T_BEZ = 6'b101000, T_BNE = 6'b101001, T_JMP = 6'b101010;

    logic        clk;
    logic        rst;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] ex_pc;
    logic [3:0]  ex_exe_cmd;
    logic [31:0] ex_val1;
    logic [31:0] ex_val2;
    logic [31:0] ex_st_val;
    logic [4:0]  ex_dest;
    logic        ex_wb_en;
    logic        ex_mem_r_en;
    logic        ex_mem_w_en;

    id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .stall          (stall),
        .wb_en          (wb_en),
        .wb_dest        (wb_dest),
        .wb_value       (wb_value),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .ex_pc          (ex_pc),
        .ex_exe_cmd     (ex_exe_cmd),
        .ex_val1        (ex_val1),
        .ex_val2        (ex_val2),
        .ex_st_val      (ex_st_val),
        .ex_dest        (ex_dest),
        .ex_wb_en       (ex_wb_en),
        .ex_mem_r_en    (ex_mem_r_en),
        .ex_mem_w_en    (ex_mem_w_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // R-type opcodes in execute-command order: command = index + 1
    logic [5:0] r_ops [10] = '{6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
                               6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100};
    // Pool for random instructions, including two unassigned opcodes
    logic [5:0] op_pool [20] = '{6'b000000, 6'b000001, 6'b000011, 6'b000101, 6'b000110,
                                 6'b000111, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                                 6'b001100, 6'b100000, 6'b100001, 6'b100100, 6'b100101,
                                 6'b101000, 6'b101001, 6'b101010, 6'b111111, 6'b010101};

    // ------------------------------------------------------------ model state
    logic [31:0]  m_rf [32];
    logic [31:0]  m_instr;
    logic [31:0]  m_pc;
    logic [139:0] m_ex_exp;   // expected ID/EX contents, packed
    logic [139:0] m_ex_care;  // fields whose value the instruction defines

    // Per-cycle observations and expectations
    logic         c_obs_taken, c_exp_taken;
    logic [31:0]  c_obs_addr,  c_exp_addr;
    logic [139:0] c_obs_ex;

    function automatic logic [139:0] pack_ex(input logic [31:0] pc, input logic [3:0] cmd,
                                             input logic [31:0] v1, v2, st, input logic [4:0] dest,
                                             input logic wb, mr, mw);
        return {pc, cmd, v1, v2, st, dest, wb, mr, mw};
    endfunction

    function automatic logic [139:0] dut_ex();
        return pack_ex(ex_pc, ex_exe_cmd, ex_val1, ex_val2, ex_st_val, ex_dest,
                       ex_wb_en, ex_mem_r_en, ex_mem_w_en);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_dest == a) return wb_value;
        return m_rf[a];
    endfunction

    function automatic int r_index(input logic [5:0] op);
        for (int i = 0; i < 10; i++) if (r_ops[i] == op) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_instr   = 32'd0;
        m_pc      = 32'd0;
        m_ex_exp  = '0;
        m_ex_care = '1;
    endtask

    // Evaluates the model for the current inputs, then advances it one edge
    task automatic model_cycle();
        logic [5:0]   op;
        logic [31:0]  v1, v2, off;
        logic [139:0] one;
        int           ri;
        op  = m_instr[31:26];
        v1  = m_read(m_instr[25:21]);
        v2  = m_read(m_instr[20:16]);
        off = {{16{m_instr[15]}}, m_instr[15:0]};
        one = '1;
        c_exp_taken = !stall && ((op == T_BEZ && v1 == 0) || (op == T_BNE && v1 != v2) || op == T_JMP);
        c_exp_addr  = m_pc + 32'd4 + off * 32'd4;
        ri = r_index(op);
        if (stall) begin
            m_ex_exp  = '0;
            m_ex_care = '1;
        end else if (ri >= 0) begin
            m_ex_exp  = pack_ex(m_pc, 4'(ri + 1), v1, v2, 0, m_instr[15:11], 1, 0, 0);
            m_ex_care = pack_ex('1, '1, '1, '1, 0, '1, 1, 1, 1);
        end else if (op == T_ADDI || op == T_SUBI || op == T_LD) begin
            m_ex_exp  = pack_ex(m_pc, (op == T_SUBI) ? 4'd2 : 4'd1, v1, off, 0, m_instr[20:16],
                                1, op == T_LD, 0);
            m_ex_care = pack_ex('1, '1, '1, '1, 0, '1, 1, 1, 1);
        end else if (op == T_ST) begin
            m_ex_exp  = pack_ex(m_pc, 0, v1, off, v2, 0, 0, 0, 1);
            m_ex_care = pack_ex('1, 0, '1, '1, '1, 0, 1, 1, 1);
        end else if (op == T_BEZ || op == T_BNE || op == T_JMP) begin
            m_ex_exp  = pack_ex(m_pc, 0, 0, 0, 0, 0, 0, 0, 0);
            m_ex_care = pack_ex('1, 0, 0, 0, 0, 0, 1, 1, 1);
        end else begin
            m_ex_exp  = pack_ex(m_pc, 0, 0, 0, 0, 0, 0, 0, 0);
            m_ex_care = pack_ex('1, '1, 0, 0, 0, 0, 1, 1, 1);
        end
        if (!stall) begin
            if (c_exp_taken) begin
                m_instr = 32'd0;
                m_pc    = 32'd0;
            end else begin
                m_instr = if_instruction;
                m_pc    = if_pc;
            end
        end
        if (wb_en && wb_dest != 0) m_rf[wb_dest] = wb_value;
        if (one == '0) m_ex_care = '0; // keeps 'one' referenced
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic cycle(input logic [31:0] instr, pc, input logic st, we,
                         input logic [4:0] wd, input logic [31:0] wv);
        if_instruction = instr;
        if_pc          = pc;
        stall          = st;
        wb_en          = we;
        wb_dest        = wd;
        wb_value       = wv;
        #1;
        c_obs_taken = branch_taken;
        c_obs_addr  = branch_address;
        model_cycle();
        @(posedge clk);
        #1;
        c_obs_ex = dut_ex();
        @(negedge clk);
    endtask

    task automatic nop_cycle();
        cycle(32'd0, 32'd0, 0, 0, 0, 0);
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_ex() !== '0) begin
            n_fail++;
            $display("FAIL reset_ex: got %h, want 0", dut_ex());
        end
        n_checks++;
        if (branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_taken: got %b, want 0", branch_taken);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_add();
        cycle(32'd0, 32'd0, 0, 1, 5'd1, 32'd1546);
        cycle({6'b000001, 5'd0, 5'd1, 5'd2, 11'd0}, 32'd8, 0, 0, 0, 0);
        nop_cycle();
        n_checks++;
        if ({ex_exe_cmd, ex_val1, ex_val2, ex_dest, ex_wb_en} !== {4'd1, 32'd0, 32'd1546, 5'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL add_r2_r0_r1: got cmd=%0d v1=%0d v2=%0d dest=%0d wb=%b, want cmd=1 v1=0 v2=1546 dest=2 wb=1",
                     ex_exe_cmd, ex_val1, ex_val2, ex_dest, ex_wb_en);
        end
    endtask

    task automatic test_branch_bez();
        logic [31:0] bez;
        bez = {T_BEZ, 5'd5, 5'd0, 16'd1};
        cycle(bez, 32'd92, 0, 1, 5'd5, 32'd1546);
        cycle(32'd0, 32'd96, 0, 0, 0, 0);
        n_checks++;
        if (c_obs_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL bez_nonzero_taken: got %b, want 0", c_obs_taken);
        end
        cycle(bez, 32'd92, 0, 1, 5'd5, 32'd0);
        cycle({T_ADD, 5'd0, 5'd1, 5'd2, 11'd0}, 32'd96, 0, 0, 0, 0);
        n_checks++;
        if ({c_obs_taken, c_obs_addr} !== {1'b1, 32'd100}) begin
            n_fail++;
            $display("FAIL bez_zero_redirect: got taken=%b addr=%0d, want taken=1 addr=100", c_obs_taken, c_obs_addr);
        end
        n_checks++;
        if ({ex_pc, ex_wb_en, ex_mem_r_en, ex_mem_w_en} !== {32'd92, 3'b000}) begin
            n_fail++;
            $display("FAIL bez_in_idex: got pc=%0d flags=%b%b%b, want pc=92 flags=000", ex_pc, ex_wb_en, ex_mem_r_en, ex_mem_w_en);
        end
        nop_cycle();
        n_checks++;
        if ({c_obs_taken, ex_exe_cmd, ex_wb_en} !== {1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL bez_flush: got taken=%b cmd=%0d wb=%b, want 0 0 0", c_obs_taken, ex_exe_cmd, ex_wb_en);
        end
    endtask

    task automatic test_jmp();
        cycle({T_JMP, 5'd0, 5'd0, 16'hFFFF}, 32'd420, 0, 0, 0, 0);
        cycle(32'd0, 32'd424, 0, 0, 0, 0);
        n_checks++;
        if ({c_obs_taken, c_obs_addr} !== {1'b1, 32'd420}) begin
            n_fail++;
            $display("FAIL jmp_minus1: got taken=%b addr=%0d, want taken=1 addr=420", c_obs_taken, c_obs_addr);
        end
    endtask

    task automatic test_store();
        cycle(32'd0, 32'd0, 0, 1, 5'd1, 32'd1024);
        cycle(32'd0, 32'd0, 0, 1, 5'd2, 32'd7);
        cycle({T_ST, 5'd1, 5'd2, 16'd20}, 32'd40, 0, 0, 0, 0);
        nop_cycle();
        n_checks++;
        if ({ex_val1, ex_val2, ex_st_val, ex_mem_w_en, ex_wb_en, ex_mem_r_en} !==
            {32'd1024, 32'd20, 32'd7, 3'b100}) begin
            n_fail++;
            $display("FAIL store: got v1=%0d v2=%0d st=%0d mw=%b wb=%b mr=%b, want 1024 20 7 1 0 0",
                     ex_val1, ex_val2, ex_st_val, ex_mem_w_en, ex_wb_en, ex_mem_r_en);
        end
    endtask

    task automatic test_bypass();
        cycle(32'd0, 32'd0, 0, 1, 5'd1, 32'd5);
        cycle(32'd0, 32'd0, 0, 1, 5'd3, 32'd9);
        cycle({T_BNE, 5'd1, 5'd3, 16'd8}, 32'd60, 0, 0, 0, 0);
        cycle(32'd0, 32'd64, 0, 1, 5'd3, 32'd5);
        n_checks++;
        if (c_obs_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL bne_bypass: got taken=%b, want 0", c_obs_taken);
        end
        // Writes to R0, both in the reading cycle and before a later read
        cycle({T_ADD, 5'd0, 5'd1, 5'd4, 11'd0}, 32'd68, 0, 0, 0, 0);
        cycle(32'd0, 32'd72, 0, 1, 5'd0, 32'd123);
        n_checks++;
        if ({ex_val1, ex_val2} !== {32'd0, 32'd5}) begin
            n_fail++;
            $display("FAIL r0_same_cycle: got v1=%0d v2=%0d, want 0 5", ex_val1, ex_val2);
        end
        cycle({T_ADD, 5'd0, 5'd1, 5'd4, 11'd0}, 32'd76, 0, 0, 0, 0);
        nop_cycle();
        n_checks++;
        if (ex_val1 !== 32'd0) begin
            n_fail++;
            $display("FAIL r0_after_write: got %0d, want 0", ex_val1);
        end
    endtask

    task automatic test_stall();
        cycle({T_JMP, 5'd0, 5'd0, 16'd3}, 32'd200, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle({T_ADD, 5'd0, 5'd1, 5'd2, 11'd0}, 32'd204, 1, 0, 0, 0);
            n_checks++;
            if ({c_obs_taken, c_obs_ex} !== '0) begin
                n_fail++;
                $display("FAIL stall_bubble_%0d: got taken=%b ex=%h, want all 0", i, c_obs_taken, c_obs_ex);
            end
        end
        cycle({T_ADD, 5'd0, 5'd1, 5'd2, 11'd0}, 32'd204, 0, 0, 0, 0);
        n_checks++;
        if ({c_obs_taken, c_obs_addr, ex_pc, ex_wb_en} !== {1'b1, 32'd216, 32'd200, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold: got taken=%b addr=%0d ex_pc=%0d wb=%b, want 1 216 200 0",
                     c_obs_taken, c_obs_addr, ex_pc, ex_wb_en);
        end
    endtask

    task automatic test_midstream_reset();
        cycle(32'd0, 32'd0, 0, 1, 5'd1, 32'd77);
        cycle({T_ADD, 5'd1, 5'd1, 5'd6, 11'd0}, 32'd300, 0, 0, 0, 0);
        cycle({T_JMP, 5'd0, 5'd0, 16'd5}, 32'd304, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({branch_taken, dut_ex()} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got taken=%b ex=%h, want all 0", branch_taken, dut_ex());
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle({T_ADD, 5'd0, 5'd1, 5'd2, 11'd0}, 32'd8, 0, 0, 0, 0);
        nop_cycle();
        n_checks++;
        if ({ex_pc, ex_exe_cmd, ex_val2, ex_dest, ex_wb_en} !== {32'd8, 4'd1, 32'd0, 5'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL after_reset: got pc=%0d cmd=%0d v2=%0d dest=%0d wb=%b, want 8 1 0 2 1",
                     ex_pc, ex_exe_cmd, ex_val2, ex_dest, ex_wb_en);
        end
    endtask

    task automatic test_random();
        logic [31:0] instr, val;
        for (int n = 0; n < 400; n++) begin
            instr = {op_pool[$urandom_range(0, 19)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     16'($urandom)};
            case ($urandom_range(0, 2))
                0:       val = 32'd0;
                1:       val = 32'($urandom_range(0, 3));
                default: val = $urandom;
            endcase
            cycle(instr, 32'(n * 4 + 1000), $urandom_range(0, 7) == 0, 1'($urandom),
                  5'($urandom_range(0, 7)), val);
            n_checks++;
            if (c_obs_taken !== c_exp_taken || (c_exp_taken && c_obs_addr !== c_exp_addr)) begin
                n_fail++;
                $display("FAIL rand_branch[%0d]: got taken=%b addr=%h, want taken=%b addr=%h",
                         n, c_obs_taken, c_obs_addr, c_exp_taken, c_exp_addr);
            end
            n_checks++;
            if ((c_obs_ex & m_ex_care) !== (m_ex_exp & m_ex_care)) begin
                n_fail++;
                $display("FAIL rand_idex[%0d]: got %h, want %h (mask %h)",
                         n, c_obs_ex & m_ex_care, m_ex_exp & m_ex_care, m_ex_care);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if_instruction = '0;
        if_pc = '0;
        stall = 1'b0;
        wb_en = 1'b0;
        wb_dest = '0;
        wb_value = '0;
        model_reset();
        test_reset();
        test_add();
        test_branch_bez();
        test_jmp();
        test_store();
        test_bypass();
        test_stall();
        test_midstream_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
